// File: rtl/seg_disp_arb_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the seven-segment display write path:
//   - default requester and digit counts
//   - arbiter FSM state encoding
//   - 4-bit hex digit type used by the seg driver
// ---------------------------------------------------------------------------
package seg_pkg;

    localparam int NREQ_DEF = 4;
    localparam int NDIG_DEF = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_GNT  = 1'b1
    } state_t;

    typedef logic [3:0] hex_t;

endpackage

// File: rtl/seg_disp_arb_if.sv
// ---------------------------------------------------------------------------
// seg_disp_arb_if
// Bundles the producer-facing write request bus and the display-facing
// outputs of seg_disp_arb.
//   clr     : single-cycle display clear
//   req     : per-requester write request
//   wr_dig  : per-requester digit index (slice i = requester i)
//   wr_val  : per-requester hex value   (slice i = requester i)
//   gnt     : one-hot registered grant
//   busy    : arbiter is in its grant cycle
//   o_hex   : registered digit values (slice d = digit d)
//   o_en    : per-digit enable, 0 = blank
// master = producers/display side, slave = the arbiter itself.
// ---------------------------------------------------------------------------
interface seg_disp_arb_if
    import seg_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int NDIG = NDIG_DEF,
    parameter int DW   = (NDIG > 1) ? $clog2(NDIG) : 1
);

    logic                 clr;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   wr_dig;
    logic [NREQ*4-1:0]    wr_val;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic [NDIG*4-1:0]    o_hex;
    logic [NDIG-1:0]      o_en;

    modport master (
        output clr, req, wr_dig, wr_val,
        input  gnt, busy, o_hex, o_en
    );

    modport slave (
        input  clr, req, wr_dig, wr_val,
        output gnt, busy, o_hex, o_en
    );

endinterface

// File: rtl/seg_disp_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts one past the
// last-granted index (ptr) and wraps, so the most recent winner has the
// lowest priority.
//   req : request vector
//   ptr : index of the last granted requester
//   win : one-hot winner, all zero when nothing is requested
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win
);

    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                win[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_disp_arb.sv
// ---------------------------------------------------------------------------
// seg_disp_arb
// Round-robin write arbiter plus digit register file for the eight-digit
// seven-segment display. One requester is granted per two cycles; its write
// commits on the edge that ends the grant cycle. clr blanks the display and
// overrides any write in flight.
//   clk : system clock
//   rst : asynchronous active-low reset
//   bus : seg_disp_arb_if.slave (requests in, grant and digit state out)
// ---------------------------------------------------------------------------
module seg_disp_arb
    import seg_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int NDIG = NDIG_DEF
) (
    input  logic          clk,
    input  logic          rst,
    seg_disp_arb_if.slave bus
);

    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q,   gnt_d;
    logic [PW-1:0]   ptr_q,   ptr_d;
    hex_t            hex_q [NDIG];
    hex_t            hex_d [NDIG];
    logic [NDIG-1:0] en_q,    en_d;
    logic [NREQ-1:0] win;

    function automatic logic [PW-1:0] oh_to_idx(input logic [NREQ-1:0] oh);
        logic [PW-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = PW'(i);
        end
        return idx;
    endfunction

    rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
        .req (bus.req),
        .ptr (ptr_q),
        .win (win)
    );

    always_comb begin
        logic [PW-1:0] w;
        logic [DW-1:0] dig;
        state_d = state_q;
        gnt_d   = '0;
        ptr_d   = ptr_q;
        hex_d   = hex_q;
        en_d    = en_q;
        w       = oh_to_idx(gnt_q);
        dig     = bus.wr_dig[int'(w)*DW +: DW];
        case (state_q)
            S_IDLE: begin
                if (bus.clr) begin
                    hex_d = '{default: '0};
                    en_d  = '0;
                end else if (|bus.req) begin
                    gnt_d   = win;
                    ptr_d   = oh_to_idx(win);
                    state_d = S_GNT;
                end
            end
            S_GNT: begin
                state_d = S_IDLE;
                // A clear arriving during the grant cycle discards the write.
                if (bus.clr) begin
                    hex_d = '{default: '0};
                    en_d  = '0;
                end else if (int'(dig) < NDIG) begin
                    hex_d[dig] = bus.wr_val[int'(w)*4 +: 4];
                    en_d[dig]  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= PW'(NREQ - 1);
            hex_q   <= '{default: '0};
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            hex_q   <= hex_d;
            en_q    <= en_d;
        end
    end

    assign bus.gnt  = gnt_q;
    assign bus.busy = (state_q == S_GNT);
    assign bus.o_en = en_q;

    for (genvar d = 0; d < NDIG; d++) begin : g_hex
        assign bus.o_hex[d*4 +: 4] = hex_q[d];
    end

endmodule

// File: doc/seg_disp_arb.md
# seg_disp_arb

Round-robin write arbiter and digit register file for the eight-digit seven-segment display. Several producers (switch priority encoder, counters, debug sources) request to write a 4-bit hex value into one display digit; the block grants one requester at a time, commits the write, and presents the registered digit values and enables to the `seg` driver. A global clear blanks the display.

## Interface
- `NREQ`, default 4: number of requesters.
- `NDIG`, default 8: number of display digits.
- `DW`, derived as `$clog2(NDIG)`: digit index width.

- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `clr`  in  1  single-cycle clear; blanks all digits.
- `req`  in  NREQ  per-requester write request; held until granted.
- `wr_dig`  in  NREQ*DW  digit index per requester, with slice i belonging to requester i.
- `wr_val`  in  NREQ*4  hex value per requester, with slice i belonging to requester i.
- `gnt`  out  NREQ  one-hot grant, registered, asserted for one cycle.
- `busy`  out  1  high while in state GNT.
- `o_hex`  out  NDIG*4  digit values, with slice d belonging to digit d.
- `o_en`  out  NDIG  per-digit enable; 0 means blank.

## Operation
- FSM with two states.
  - IDLE: if `clr`=0 and any `req` bit is set, the round-robin arbiter picks a winner and the FSM moves to GNT with `gnt` loaded one-hot.
  - GNT: lasts exactly one cycle, then returns to IDLE unconditionally.
  - At most one grant occurs per two cycles.
- Write commit happens on the clock edge that ends the GNT cycle.
  - `o_hex[wr_dig[w]]` is set to `wr_val[w]` and `o_en[wr_dig[w]]` is set to 1, where w is the granted requester.
  - The values written are those present during the GNT cycle, so the requester must hold `wr_dig` and `wr_val` stable from `req` rise through its `gnt` cycle.
- Requester protocol:
  - A requester drops `req`, or presents new data, in the cycle after seeing `gnt`.
  - If `req` is still high in that cycle, it is treated as a new request.
- Round-robin priority:
  - The pointer holds the last granted index; the search starts at pointer+1 and wraps modulo NREQ.
  - After reset the pointer is NREQ-1, so requester 0 has first priority.
  - The pointer updates only when a grant is issued.
- If `req` drops during GNT, the write still commits, because the grant is already issued.
- `clr`:
  - In IDLE, `clr`=1 blocks the arbitration, and all `o_hex` and `o_en` bits clear at the next edge.
  - In GNT, `clr` wins: all digits are cleared and the pending write is discarded. `gnt` has already been shown, so the requester treats the write as lost to the clear.
- An out-of-range `wr_dig` (≥NDIG, possible only when NDIG is not a power of two) makes the write a no-op; the grant is still consumed.

## Timing
- Reset (`rst`=0, asynchronous) sets:
  - state to IDLE,
  - `gnt`=0 and `busy`=0,
  - `o_hex`=0 and `o_en`=0,
  - the pointer to NREQ-1.
- Reset asserted mid-GNT aborts the write immediately. Deassertion is synchronised externally.
- Latency:
  - `gnt` asserts 1 cycle after `req` is sampled in IDLE.
  - `o_hex`/`o_en` update 1 cycle after `gnt`, i.e. 2 cycles after `req`.
- Every output is a flop output; there is no combinational path from input to output.
- Under continuous requests from all NREQ requesters, each is granted once every 2*NREQ cycles.

## Structure
- Shared package `seg_pkg` holds:
  - the defaults for NREQ and NDIG,
  - the state enum `{S_IDLE, S_GNT}`,
  - the 4-bit hex type used by the `seg` driver.
- Sub-module `rr_arbiter` (parameter N; ports `req`, `ptr`, and a combinational one-hot `win`) contains only the arbitration logic, for reuse elsewhere.
- The top level contains the FSM, the pointer register, the digit register file and the clear logic.

## Test plan
- Reset: hold `rst`=0 with `req`=4'hF, then release. Require `o_en`=0, `o_hex`=0 and `gnt`=0 throughout reset, and first `gnt`=4'b0001 two cycles after release.
- Single write: `req[2]` with `wr_dig[2]`=5 and `wr_val[2]`=4'hA. Require `gnt`=4'b0100 one cycle later, and `o_hex` digit 5 = A with `o_en`=8'b0010_0000 the next cycle.
- Fairness: hold `req`=4'hF with distinct digits. Require the grant sequence 0,1,2,3,0 on every other cycle, and all four digits written.
- Same digit: req0 writes digit 3=4'h1 and req1 writes digit 3=4'h7, both held once. Require final digit 3 = 7, because the later grant wins.
- Clear collision: assert `clr` during a GNT cycle for a write of digit 0=4'hC. Require `o_en`=0 afterwards, digit 0 not written, and the FSM back in IDLE.
- Reset mid-GNT: drop `rst` during GNT. Require no digit update, all outputs 0, and the pointer restored so requester 0 is granted first.
